// File: rtl/iic_pkg.sv
// Shared IIC definitions: arbiter FSM states, operation type codes and
// descriptor field widths common to iic_arbiter and iic_driver.
package iic_pkg;

  localparam int P_DEV_ADDR_W = 7;
  localparam int P_MEM_ADDR_W = 16;
  localparam int P_LEN_W      = 8;
  localparam int P_DATA_W     = 8;

  localparam logic P_WRITE = 1'b0;
  localparam logic P_READ  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_LOW,
    ST_BUSY,
    ST_DONE
  } arb_state_t;

endpackage

// File: rtl/iic_rr_pick.sv
// Combinational requester pick: first valid at or after the pointer, wrapping.
// With IIC_ARB_FIXED_PRIO_EN defined the search always starts at index 0.
module iic_rr_pick
  import iic_pkg::*;
#(
  parameter int P_CLIENTS = 2,
  parameter int P_IDX_W   = 3
) (
  input  logic [P_CLIENTS-1:0] i_valid,
  input  logic [P_IDX_W-1:0]   i_ptr,
  output logic [P_IDX_W-1:0]   o_winner,
  output logic                 o_any_valid
);

  int start_idx;
  int cand_idx;

  always_comb begin
    o_winner    = '0;
    o_any_valid = 1'b0;
`ifdef IIC_ARB_FIXED_PRIO_EN
    start_idx   = 0;
`else
    start_idx   = int'(i_ptr);
`endif
    cand_idx    = 0;
    // Visit candidates in priority order; the first valid one sticks.
    for (int i = 0; i < P_CLIENTS; i++) begin
      cand_idx = start_idx + i;
      if (cand_idx >= P_CLIENTS) cand_idx = cand_idx - P_CLIENTS;
      for (int k = 0; k < P_CLIENTS; k++) begin
        if (!o_any_valid && (cand_idx == k) && i_valid[k]) begin
          o_winner    = P_IDX_W'(k);
          o_any_valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/iic_arbiter.sv
// Shares one iic_driver between P_CLIENTS requesters, holding the grant for a
// whole transaction. Define IIC_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
module iic_arbiter
  import iic_pkg::*;
#(
  parameter int P_CLIENTS = 2,
  parameter int P_IDX_W   = 3
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [P_DEV_ADDR_W*P_CLIENTS-1:0] i_req_driver_addr,
  input  logic [P_MEM_ADDR_W*P_CLIENTS-1:0] i_req_operation_addr,
  input  logic [P_LEN_W*P_CLIENTS-1:0]    i_req_operation_len,
  input  logic [P_CLIENTS-1:0]            i_req_operation_type,
  input  logic [P_CLIENTS-1:0]            i_req_operation_valid,
  output logic [P_CLIENTS-1:0]            o_req_operation_ready,
  input  logic [P_DATA_W*P_CLIENTS-1:0]   i_req_write_data,
  output logic [P_CLIENTS-1:0]            o_req_write_req,
  output logic [P_DATA_W-1:0]             o_req_read_data,
  output logic [P_CLIENTS-1:0]            o_req_read_valid,
  output logic [P_CLIENTS-1:0]            o_req_done,
  output logic [P_DEV_ADDR_W-1:0]         o_drv_driver_addr,
  output logic [P_MEM_ADDR_W-1:0]         o_drv_operation_addr,
  output logic [P_LEN_W-1:0]              o_drv_operation_len,
  output logic                            o_drv_operation_type,
  output logic                            o_drv_operation_valid,
  input  logic                            i_drv_operation_ready,
  output logic [P_DATA_W-1:0]             o_drv_write_data,
  input  logic                            i_drv_write_req,
  input  logic [P_DATA_W-1:0]             i_drv_read_data,
  input  logic                            i_drv_read_valid
);

  arb_state_t                state_q, state_d;
  logic [P_IDX_W-1:0]        grant_q, grant_d;
  logic [P_IDX_W-1:0]        ptr_q, ptr_d;
  logic [P_DEV_ADDR_W-1:0]   dev_addr_q, dev_addr_d;
  logic [P_MEM_ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [P_LEN_W-1:0]        len_q, len_d;
  logic                      type_q, type_d;
  logic [P_CLIENTS-1:0]      done_q, done_d;

  logic [P_IDX_W-1:0]        winner;
  logic                      any_valid;
  logic [P_DEV_ADDR_W-1:0]   sel_dev_addr;
  logic [P_MEM_ADDR_W-1:0]   sel_mem_addr;
  logic [P_LEN_W-1:0]        sel_len;
  logic                      sel_type;
  logic [P_DATA_W-1:0]       sel_wr_data;
  logic                      active;

  iic_rr_pick #(
    .P_CLIENTS (P_CLIENTS),
    .P_IDX_W   (P_IDX_W)
  ) u_pick (
    .i_valid     (i_req_operation_valid),
    .i_ptr       (ptr_q),
    .o_winner    (winner),
    .o_any_valid (any_valid)
  );

  always_comb begin
    sel_dev_addr = '0;
    sel_mem_addr = '0;
    sel_len      = '0;
    sel_type     = 1'b0;
    sel_wr_data  = '0;
    for (int k = 0; k < P_CLIENTS; k++) begin
      if (winner == P_IDX_W'(k)) begin
        sel_dev_addr = i_req_driver_addr[k*P_DEV_ADDR_W +: P_DEV_ADDR_W];
        sel_mem_addr = i_req_operation_addr[k*P_MEM_ADDR_W +: P_MEM_ADDR_W];
        sel_len      = i_req_operation_len[k*P_LEN_W +: P_LEN_W];
        sel_type     = i_req_operation_type[k];
      end
      if (grant_q == P_IDX_W'(k)) begin
        sel_wr_data = i_req_write_data[k*P_DATA_W +: P_DATA_W];
      end
    end
  end

  always_comb begin
    state_d               = state_q;
    grant_d               = grant_q;
    ptr_d                 = ptr_q;
    dev_addr_d            = dev_addr_q;
    mem_addr_d            = mem_addr_q;
    len_d                 = len_q;
    type_d                = type_q;
    done_d                = '0;
    o_req_operation_ready = '0;
    o_drv_operation_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // Only grant when the driver can take the operation right away.
        if (i_drv_operation_ready && any_valid) begin
          for (int k = 0; k < P_CLIENTS; k++) begin
            o_req_operation_ready[k] = (winner == P_IDX_W'(k));
          end
          grant_d    = winner;
          dev_addr_d = sel_dev_addr;
          mem_addr_d = sel_mem_addr;
          len_d      = sel_len;
          type_d     = sel_type;
          state_d    = (sel_len == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        o_drv_operation_valid = 1'b1;
        if (i_drv_operation_ready) state_d = ST_WAIT_LOW;
      end
      ST_WAIT_LOW: begin
        if (!i_drv_operation_ready) state_d = ST_BUSY;
      end
      ST_BUSY: begin
        if (i_drv_operation_ready) state_d = ST_DONE;
      end
      ST_DONE: begin
        for (int k = 0; k < P_CLIENTS; k++) begin
          done_d[k] = (grant_q == P_IDX_W'(k));
        end
`ifdef IIC_ARB_FIXED_PRIO_EN
        ptr_d = '0;
`else
        ptr_d = (grant_q == P_IDX_W'(P_CLIENTS - 1)) ? '0 : grant_q + 1'b1;
`endif
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Driver strobes only reach the granted client while a grant is held.
  always_comb begin
    active           = (state_q != ST_IDLE);
    o_req_write_req  = '0;
    o_req_read_valid = '0;
    for (int k = 0; k < P_CLIENTS; k++) begin
      o_req_write_req[k]  = i_drv_write_req  && active && (grant_q == P_IDX_W'(k));
      o_req_read_valid[k] = i_drv_read_valid && active && (grant_q == P_IDX_W'(k));
    end
    o_drv_write_data = active ? sel_wr_data : '0;
    o_req_read_data  = active ? i_drv_read_data : '0;
  end

  assign o_drv_driver_addr    = dev_addr_q;
  assign o_drv_operation_addr = mem_addr_q;
  assign o_drv_operation_len  = len_q;
  assign o_drv_operation_type = type_q;
  assign o_req_done           = done_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      ptr_q      <= '0;
      dev_addr_q <= '0;
      mem_addr_q <= '0;
      len_q      <= '0;
      type_q     <= 1'b0;
      done_q     <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      dev_addr_q <= dev_addr_d;
      mem_addr_q <= mem_addr_d;
      len_q      <= len_d;
      type_q     <= type_d;
      done_q     <= done_d;
    end
  end

endmodule
